// File: rtl/ikascc_waveram_sched.sv
// Wave RAM access scheduler: one single-port wave RAM shared by five sample-fetch
// channels and the CPU, one access per three enable edges (IDLE -> ADDR -> DATA).
module ikascc_waveram_sched #(
   parameter int SHARE_CH45 = 1
) (
   input  logic        i_EMUCLK,
   input  logic        i_RST,
   input  logic        i_MCLK_PCEN_n,
   input  logic [4:0]  i_CH_RQ,
   input  logic [24:0] i_CH_PTR,
   output logic [4:0]  o_CH_ACK,
   output logic [7:0]  o_CH_DATA,
   input  logic        i_CPU_RQ,
   input  logic        i_CPU_WR,
   input  logic [7:0]  i_CPU_ADDR,
   input  logic [7:0]  i_CPU_DI,
   output logic        o_CPU_ACK,
   output logic [7:0]  o_CPU_DO,
   output logic [7:0]  o_RAM_ADDR,
   output logic        o_RAM_WE,
   output logic [7:0]  o_RAM_DI,
   input  logic [7:0]  i_RAM_DO
);

   typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_t;

   state_t     state, state_nxt;
   logic       en;
   logic [2:0] last_ch;
   logic       last_cpu;
   logic       cur_cpu;
   logic [2:0] cur_ch;
   logic       cur_oob;

   logic [4:0] ch_avail;
   logic       cpu_avail;
   logic       grant_cpu;
   logic       grant_ch;
   logic       ch_found;
   logic [2:0] ch_pick;
   logic [3:0] rr_idx;
   logic [4:0] ch_ptr;
   logic [2:0] ch_table;
   logic       cpu_oob;
   logic [7:0] cpu_addr_map;

   assign en = ~i_MCLK_PCEN_n;

   // A requester still showing its ack was served on the last DATA edge; skip it once.
   assign ch_avail  = i_CH_RQ & ~o_CH_ACK;
   assign cpu_avail = i_CPU_RQ & ~o_CPU_ACK;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path infers a latch.
      ch_found = 1'b0;
      ch_pick  = 3'd0;
      rr_idx   = 4'd0;
      for (int i = 1; i <= 5; i++) begin
         rr_idx = {1'b0, last_ch} + 4'(i);
         if (rr_idx >= 4'd5) rr_idx = rr_idx - 4'd5;
         if (!ch_found && ch_avail[rr_idx[2:0]]) begin
            ch_found = 1'b1;
            ch_pick  = rr_idx[2:0];
         end
      end
   end

   assign grant_cpu = (state == ST_IDLE) && cpu_avail && !(last_cpu && (|ch_avail));
   assign grant_ch  = (state == ST_IDLE) && !grant_cpu && ch_found;

   always_comb begin
      case (ch_pick)
         3'd0:    ch_ptr = i_CH_PTR[4:0];
         3'd1:    ch_ptr = i_CH_PTR[9:5];
         3'd2:    ch_ptr = i_CH_PTR[14:10];
         3'd3:    ch_ptr = i_CH_PTR[19:15];
         default: ch_ptr = i_CH_PTR[24:20];
      endcase
   end

   assign ch_table     = (SHARE_CH45 != 0 && ch_pick == 3'd4) ? 3'd3 : ch_pick;
   assign cpu_oob      = (i_CPU_ADDR >= 8'd160);
   assign cpu_addr_map = (SHARE_CH45 != 0 && i_CPU_ADDR >= 8'd128) ? (i_CPU_ADDR - 8'd32) : i_CPU_ADDR;

   always_ff @(posedge i_EMUCLK or posedge i_RST) begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      if (i_RST)   state <= ST_IDLE;
      else if (en) state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (grant_cpu || grant_ch) state_nxt = ST_ADDR;
         ST_ADDR: state_nxt = ST_DATA;
         ST_DATA: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_EMUCLK or posedge i_RST) begin
      if (i_RST) begin
         o_CH_ACK   <= 5'd0;
         o_CPU_ACK  <= 1'b0;
         o_CH_DATA  <= 8'd0;
         o_CPU_DO   <= 8'd0;
         o_RAM_ADDR <= 8'd0;
         o_RAM_WE   <= 1'b0;
         o_RAM_DI   <= 8'd0;
         last_ch    <= 3'd4;
         last_cpu   <= 1'b0;
         cur_cpu    <= 1'b0;
         cur_ch     <= 3'd0;
         cur_oob    <= 1'b0;
      end else if (en) begin
         o_CH_ACK  <= 5'd0;
         o_CPU_ACK <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (grant_cpu) begin
                  cur_cpu  <= 1'b1;
                  cur_oob  <= cpu_oob;
                  last_cpu <= 1'b1;
                  if (!cpu_oob) o_RAM_ADDR <= cpu_addr_map;
                  if (i_CPU_WR && !cpu_oob) begin
                     o_RAM_WE <= 1'b1;
                     o_RAM_DI <= i_CPU_DI;
                  end
               end else if (grant_ch) begin
                  cur_cpu    <= 1'b0;
                  cur_ch     <= ch_pick;
                  last_ch    <= ch_pick;
                  last_cpu   <= 1'b0;
                  o_RAM_ADDR <= {ch_table, ch_ptr};
               end
            end
            ST_ADDR: o_RAM_WE <= 1'b0;
            ST_DATA: begin
               if (cur_cpu) begin
                  o_CPU_ACK <= 1'b1;
                  o_CPU_DO  <= cur_oob ? 8'hFF : i_RAM_DO;
               end else begin
                  o_CH_ACK  <= 5'd1 << cur_ch;
                  o_CH_DATA <= i_RAM_DO;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/ikascc_waveram_sched.md
IKASCC_WAVERAM_SCHED -- requirements
Module: ikascc_waveram_sched

Interface
REQ-001 Parameter: SHARE_CH45, default 1, meaning channel 4 reads wavetable 3 and CPU addresses 128-159 alias to 96-127.
REQ-002 i_EMUCLK  in  1  emulator master clock; the only clock.
REQ-003 i_RST  in  1  reset, asynchronous, active-high.
REQ-004 i_MCLK_PCEN_n  in  1  clock enable, active-low; all state advances only on i_EMUCLK edges with i_MCLK_PCEN_n=0 ("enable edge").
REQ-005 i_CH_RQ  in  5  per-channel sample fetch request, level, bit n = channel n.
REQ-006 i_CH_PTR  in  25  per-channel 5-bit sample pointer, channel n at bits [5n+4:5n].
REQ-007 o_CH_ACK  out  5  one-hot fetch acknowledge.
REQ-008 o_CH_DATA  out  8  fetched sample byte, valid while o_CH_ACK is nonzero.
REQ-009 i_CPU_RQ  in  1  CPU wave RAM access request, level.
REQ-010 i_CPU_WR  in  1  1 = write, 0 = read.
REQ-011 i_CPU_ADDR  in  8  CPU wave RAM address.
REQ-012 i_CPU_DI  in  8  CPU write data.
REQ-013 o_CPU_ACK  out  1  CPU access acknowledge.
REQ-014 o_CPU_DO  out  8  CPU read data, valid while o_CPU_ACK=1.
REQ-015 o_RAM_ADDR  out  8  single-port wave RAM address, registered.
REQ-016 o_RAM_WE  out  1  wave RAM write enable, registered.
REQ-017 o_RAM_DI  out  8  wave RAM write data, registered.
REQ-018 i_RAM_DO  in  8  wave RAM read data, valid one enable edge after the address.

Function
REQ-019 FSM states IDLE, ADDR, DATA; transitions: IDLE->ADDR on grant, ADDR->DATA unconditional, DATA->IDLE unconditional; one transition per enable edge.
REQ-020 In IDLE the block grants one requester per enable edge; with no active request it stays in IDLE and all acks are 0.
REQ-021 CPU has priority over channels, except when the previous grant was CPU and any channel request is active; the channel is then granted.
REQ-022 Channels are arbitrated round-robin; search starts at (last-served channel + 1) mod 5.
REQ-023 The requester acked on the previous DATA edge is masked for the immediately following IDLE evaluation.
REQ-024 Channel address = {table, ptr}; table = n, except n=4 with SHARE_CH45=1, where table = 3.
REQ-025 CPU address 0-127 is used directly; 128-159 maps to addr-32 when SHARE_CH45=1 and is used directly when SHARE_CH45=0.
REQ-026 CPU address >=160 is granted normally, but the RAM is not accessed and o_RAM_WE stays 0; a read returns o_CPU_DO=0xFF.
REQ-027 On the IDLE->ADDR edge o_RAM_ADDR is loaded; for a CPU write o_RAM_DI=i_CPU_DI and o_RAM_WE=1.
REQ-028 On the ADDR->DATA edge o_RAM_WE is cleared, so every write is exactly one enable period.
REQ-029 On the DATA->IDLE edge i_RAM_DO is captured into o_CH_DATA or o_CPU_DO, and the matching ack goes to 1 for exactly one enable period.
REQ-030 Latency: request sampled in IDLE at edge k; ack asserted after edge k+2.
REQ-031 Peak throughput: one access per 3 enable edges.
REQ-032 Request inputs, pointer, address and write data are sampled only at the IDLE grant edge; later changes do not affect the access in flight.
REQ-033 o_CH_DATA and o_CPU_DO hold their last value when the matching ack is 0.
REQ-034 Acks are mutually exclusive; at most one bit of {o_CH_ACK, o_CPU_ACK} is 1.
REQ-035 With i_MCLK_PCEN_n held at 1, state and all outputs are frozen.

Reset
REQ-036 While i_RST=1 (asynchronous): state=IDLE; o_CH_ACK=0; o_CPU_ACK=0; o_RAM_WE=0; o_RAM_ADDR=0; o_RAM_DI=0; o_CH_DATA=0; o_CPU_DO=0; last-served channel=4, so channel 0 is searched first; last grant not CPU.
REQ-037 Reset asserted mid-access aborts the access: any in-flight write is discarded, o_RAM_WE drops without waiting for a clock, and no ack is issued.
REQ-038 After reset release, the first enable edge evaluates requests in IDLE.

Verification
REQ-039 Enable every cycle; CPU write addr 0x05 data 0x7A, then CPU read addr 0x05 -> write: o_RAM_WE=1 for one cycle, addr 0x05; read: o_CPU_ACK with o_CPU_DO=0x7A, 3 cycles after the request.
REQ-040 SHARE_CH45=1; write 0x33 at CPU addr 0x70; channel 4 fetches ptr 0x10 -> o_RAM_ADDR=0x70; o_CH_ACK=5'b10000; o_CH_DATA=0x33.
REQ-041 All 5 channels and CPU request continuously -> grant order CPU, ch0, CPU, ch1, CPU, ch2, ...; no requester starves; acks one-hot.
REQ-042 CPU write addr 0xA5 -> o_RAM_WE stays 0 and o_CPU_ACK=1; CPU read addr 0xC0 -> o_CPU_DO=0xFF.
REQ-043 Assert i_RST during a CPU write's ADDR state -> o_RAM_WE=0 immediately; no ack; RAM content unchanged on readback.
REQ-044 i_MCLK_PCEN_n low 1 cycle in 4 -> ack latency is 3 enable edges; each ack is 4 i_EMUCLK cycles wide.
